free_play_fsm: RTL and testbench

Parametrised free-play keyboard controller, successor to the fixed 4-key free-mode FSM. It decodes a held ASCII key code into a note index over NUM_KEYS contiguous keys. It applies a programmable release tail and measures the held duration of each note. It sits between the keyboard scan-code receiver and the tone generator / note-duration logger.

---
 rtl/free_play_fsm_if.sv | 37 +++
 rtl/free_play_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_free_play_fsm.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/free_play_fsm_if.sv
// free_play_fsm_if: keyboard-side inputs and
// tone-generator / logger-side outputs of free_play_fsm.
// Ports (master = keyboard side drives these):
//   start, stop   : arm / leave free-play mode (levels)
//   key_code[7:0] : currently held ASCII code
// Ports (slave = free_play_fsm drives these):
//   note[NOTE_W-1:0] : 0 = silence, i+1 = key i sounding
//   octave           : 1 = upper octave
//   playing, active  : tone count-enable, mode armed
//   note_done        : one-cycle pulse when a note ends
//   last_dur[DUR_W-1:0] : length of the finished note
interface free_play_fsm_if #(
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 16
);
  logic              start;
  logic              stop;
  logic [7:0]        key_code;
  logic [NOTE_W-1:0] note;
  logic              octave;
  logic              playing;
  logic              active;
  logic              note_done;
  logic [DUR_W-1:0]  last_dur;

  modport master (
    output start, stop, key_code,
    input  note, octave, playing,
    input  active, note_done, last_dur
  );

  modport slave (
    input  start, stop, key_code,
    output note, octave, playing,
    output active, note_done, last_dur
  );
endinterface

// File: rtl/free_play_fsm.sv
// free_play_fsm: free-play keyboard controller with
// release tail and per-note held-duration measurement.
// Ports: clk, reset (async, active-high), bus (slave
// modport of free_play_fsm_if: start/stop/key_code in,
// note/octave/playing/active/note_done/last_dur out).
// Optional: define FREE_PLAY_OCTAVE_EN to accept the
// uppercase key range as the upper octave.
module free_play_fsm #(
  parameter int NUM_KEYS = 8,
  parameter int KEY_BASE = 97,
  parameter int NOTE_W   = 4,
  parameter int MIN_HOLD = 4,
  parameter int DUR_W    = 16
) (
  input  logic           clk,
  input  logic           reset,
  free_play_fsm_if.slave bus
);

  localparam int HOLD_W =
    (MIN_HOLD > 2) ? $clog2(MIN_HOLD) : 1;
  localparam int HOLD_IV =
    (MIN_HOLD > 0) ? MIN_HOLD - 1 : 0;
  localparam logic [HOLD_W-1:0] HOLD_INIT =
    HOLD_W'(HOLD_IV);
  localparam logic [HOLD_W-1:0] HOLD_ONE =
    HOLD_W'(1);
  localparam logic [DUR_W-1:0] DUR_MAX = '1;
  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_PLAY,
    S_HOLD
  } state_t;

  state_t            state, state_n;
  logic [NOTE_W-1:0] note_q, note_n;
  logic              oct_q, oct_n;
  logic [DUR_W-1:0]  dur_q, dur_n;
  logic [DUR_W-1:0]  dur_inc;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic              done_q, done_n;
  logic [DUR_W-1:0]  last_q, last_n;
  logic              play_q, play_n;
  logic              act_q, act_n;

  int                kc;
  logic              hit;
  logic [NOTE_W-1:0] hit_note;
  logic              hit_oct;
  logic              same;
  logic              swap;

  // Key decode: lowercase range always, uppercase
  // range only with the octave build option.
  always_comb begin
    kc       = int'(bus.key_code);
    hit      = 1'b0;
    hit_note = '0;
    hit_oct  = 1'b0;
    if (kc >= KEY_BASE &&
        kc < KEY_BASE + NUM_KEYS) begin
      hit      = 1'b1;
      hit_note = NOTE_W'(kc - KEY_BASE + 1);
    end
`ifdef FREE_PLAY_OCTAVE_EN
    else if (kc >= KEY_BASE - 32 &&
             kc < KEY_BASE - 32 + NUM_KEYS) begin
      hit      = 1'b1;
      hit_note = NOTE_W'(kc - KEY_BASE + 33);
      hit_oct  = 1'b1;
    end
`endif
  end

  // A different octave of the same letter is a
  // different key, so it retriggers the note.
  assign same = hit &&
                (hit_note == note_q) &&
                (hit_oct == oct_q);
  assign swap = hit && !same;

  assign dur_inc = (dur_q == DUR_MAX) ?
                   dur_q : dur_q + DUR_ONE;

  always_comb begin
    state_n = state;
    note_n  = note_q;
    oct_n   = oct_q;
    dur_n   = dur_q;
    hold_n  = hold_q;
    done_n  = 1'b0;
    last_n  = last_q;
    if (bus.stop) begin
      state_n = S_IDLE;
      note_n  = '0;
      oct_n   = 1'b0;
      hold_n  = '0;
      if (state == S_PLAY ||
          state == S_HOLD) begin
        done_n = 1'b1;
        last_n = dur_q;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start)
            state_n = S_ARMED;
        end
        S_ARMED: begin
          if (hit) begin
            state_n = S_PLAY;
            note_n  = hit_note;
            oct_n   = hit_oct;
            dur_n   = DUR_ONE;
          end
        end
        S_PLAY: begin
          unique case (1'b1)
            same: dur_n = dur_inc;
            swap: begin
              done_n = 1'b1;
              last_n = dur_q;
              note_n = hit_note;
              oct_n  = hit_oct;
              dur_n  = DUR_ONE;
            end
            !hit: begin
              if (MIN_HOLD == 0) begin
                state_n = S_ARMED;
                done_n  = 1'b1;
                last_n  = dur_q;
                note_n  = '0;
                oct_n   = 1'b0;
              end else begin
                state_n = S_HOLD;
                hold_n  = HOLD_INIT;
                dur_n   = dur_inc;
              end
            end
            default: ;
          endcase
        end
        S_HOLD: begin
          unique case (1'b1)
            same: begin
              state_n = S_PLAY;
              dur_n   = dur_inc;
            end
            swap: begin
              state_n = S_PLAY;
              done_n  = 1'b1;
              last_n  = dur_q;
              note_n  = hit_note;
              oct_n   = hit_oct;
              dur_n   = DUR_ONE;
            end
            !hit: begin
              if (hold_q == '0) begin
                state_n = S_ARMED;
                done_n  = 1'b1;
                last_n  = dur_q;
                note_n  = '0;
                oct_n   = 1'b0;
              end else begin
                hold_n = hold_q - HOLD_ONE;
                dur_n  = dur_inc;
              end
            end
            default: ;
          endcase
        end
        default: state_n = S_IDLE;
      endcase
    end
    play_n = (state_n == S_PLAY) ||
             (state_n == S_HOLD);
    act_n  = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      note_q <= '0;
      oct_q  <= 1'b0;
      dur_q  <= '0;
      hold_q <= '0;
      done_q <= 1'b0;
      last_q <= '0;
      play_q <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      state  <= state_n;
      note_q <= note_n;
      oct_q  <= oct_n;
      dur_q  <= dur_n;
      hold_q <= hold_n;
      done_q <= done_n;
      last_q <= last_n;
      play_q <= play_n;
      act_q  <= act_n;
    end
  end

  // Without the octave option oct_q can only hold 0,
  // so the output is constant low.
  assign bus.note      = note_q;
  assign bus.octave    = oct_q;
  assign bus.playing   = play_q;
  assign bus.active    = act_q;
  assign bus.note_done = done_q;
  assign bus.last_dur  = last_q;

endmodule

// File: tb/tb_free_play_fsm.sv
// tb_free_play_fsm: directed and randomized checks of
// free_play_fsm against a note-level reference model.
module tb_free_play_fsm;

  localparam int NK  = 8;
  localparam int KB  = 97;
  localparam int MH0 = 4;
  localparam int DW0 = 16;
  localparam int MH1 = 0;
  localparam int DW1 = 4;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       start    = 1'b0;
  logic       stop     = 1'b0;
  logic [7:0] key_code = 8'd0;

  int total = 0;
  int bad   = 0;

  free_play_fsm_if #(.NOTE_W(4), .DUR_W(DW0)) b0 ();
  free_play_fsm_if #(.NOTE_W(4), .DUR_W(DW1)) b1 ();

  assign b0.start    = start;
  assign b0.stop     = stop;
  assign b0.key_code = key_code;
  assign b1.start    = start;
  assign b1.stop     = stop;
  assign b1.key_code = key_code;

  free_play_fsm #(
    .NUM_KEYS(NK), .KEY_BASE(KB), .NOTE_W(4),
    .MIN_HOLD(MH0), .DUR_W(DW0)
  ) u0 (.clk(clk), .reset(reset), .bus(b0));

  free_play_fsm #(
    .NUM_KEYS(NK), .KEY_BASE(KB), .NOTE_W(4),
    .MIN_HOLD(MH1), .DUR_W(DW1)
  ) u1 (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  // Reference model: tracks which note sounds, how
  // long it has sounded and how long since release.
  typedef struct {
    bit mode;
    int snd;
    bit soct;
    int rel;
    int dur;
    bit done;
    int last;
  } mdl_t;

  mdl_t m0, m1;

  function automatic void decode(
    input logic [7:0] k, output int idx, output bit oc);
    int v;
    v = int'(k);
    idx = 0;
    oc = 1'b0;
    if (v >= KB && v < KB + NK) idx = v - KB + 1;
`ifdef FREE_PLAY_OCTAVE_EN
    else if (v >= KB - 32 && v < KB - 32 + NK) begin
      idx = v - KB + 33;
      oc = 1'b1;
    end
`endif
  endfunction

  function automatic mdl_t mstep(
    input mdl_t m, input int mh, input int dw,
    input bit st, input bit sp, input logic [7:0] k);
    mdl_t n;
    int idx;
    bit oc;
    int cap;
    n = m;
    cap = (1 << dw) - 1;
    n.done = 1'b0;
    decode(k, idx, oc);
    if (sp) begin
      if (m.snd != 0) begin
        n.done = 1'b1;
        n.last = (m.dur > cap) ? cap : m.dur;
      end
      n.mode = 1'b0;
      n.snd = 0;
      n.soct = 1'b0;
      n.rel = 0;
      return n;
    end
    if (!m.mode) begin
      if (st) n.mode = 1'b1;
      return n;
    end
    if (m.snd == 0) begin
      if (idx != 0) begin
        n.snd = idx;
        n.soct = oc;
        n.dur = 1;
        n.rel = 0;
      end
      return n;
    end
    if (idx != 0 && idx == m.snd && oc == m.soct) begin
      n.dur = m.dur + 1;
      n.rel = 0;
    end else if (idx != 0) begin
      n.done = 1'b1;
      n.last = (m.dur > cap) ? cap : m.dur;
      n.snd = idx;
      n.soct = oc;
      n.dur = 1;
      n.rel = 0;
    end else if (m.rel < mh) begin
      n.rel = m.rel + 1;
      n.dur = m.dur + 1;
    end else begin
      n.done = 1'b1;
      n.last = (m.dur > cap) ? cap : m.dur;
      n.snd = 0;
      n.soct = 1'b0;
      n.rel = 0;
    end
    return n;
  endfunction

  task automatic mreset();
    m0 = '{default: 0};
    m1 = '{default: 0};
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m0 = mstep(m0, MH0, DW0, start, stop, key_code);
      m1 = mstep(m1, MH1, DW1, start, stop, key_code);
    end
    #1;
  endtask

  task automatic test_reset();
    mreset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (b0.note !== 4'd0) begin bad++; $display("FAIL rst_note got %0d want 0", b0.note); end
    total++; if (b0.octave !== 1'b0) begin bad++; $display("FAIL rst_octave got %0b want 0", b0.octave); end
    total++; if (b0.playing !== 1'b0) begin bad++; $display("FAIL rst_playing got %0b want 0", b0.playing); end
    total++; if (b0.active !== 1'b0) begin bad++; $display("FAIL rst_active got %0b want 0", b0.active); end
    total++; if (b0.note_done !== 1'b0) begin bad++; $display("FAIL rst_done got %0b want 0", b0.note_done); end
    total++; if (b0.last_dur !== 16'd0) begin bad++; $display("FAIL rst_last got %0d want 0", b0.last_dur); end
    total++; if (b1.active !== 1'b0) begin bad++; $display("FAIL rst_active1 got %0b want 0", b1.active); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (b0.active !== 1'b1) begin bad++; $display("FAIL arm_active got %0b want 1", b0.active); end
    total++; if (b0.note !== 4'd0) begin bad++; $display("FAIL arm_note got %0d want 0", b0.note); end
    key_code = 8'd97;
    tick();
    total++; if (b0.note !== 4'd1) begin bad++; $display("FAIL basic_note got %0d want 1", b0.note); end
    total++; if (b0.playing !== 1'b1) begin bad++; $display("FAIL basic_play got %0b want 1", b0.playing); end
    repeat (9) tick();
    key_code = 8'd0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if ({b0.playing, b0.note} !== 5'b1_0001) begin bad++; $display("FAIL tail_%0d got play=%0b note=%0d want play=1 note=1", i, b0.playing, b0.note); end
      if (i == 1) begin
        total++; if (b1.note_done !== 1'b1) begin bad++; $display("FAIL notail_done1 got %0b want 1", b1.note_done); end
        total++; if (b1.last_dur !== 4'd10) begin bad++; $display("FAIL notail_last1 got %0d want 10", b1.last_dur); end
      end
    end
    tick();
    total++; if (b0.note_done !== 1'b1) begin bad++; $display("FAIL basic_done got %0b want 1", b0.note_done); end
    total++; if (b0.last_dur !== 16'd14) begin bad++; $display("FAIL basic_last got %0d want 14", b0.last_dur); end
    total++; if ({b0.playing, b0.note} !== 5'b0) begin bad++; $display("FAIL basic_armed got play=%0b note=%0d want 0", b0.playing, b0.note); end
    total++; if (b0.active !== 1'b1) begin bad++; $display("FAIL basic_active got %0b want 1", b0.active); end
    tick();
    total++; if (b0.note_done !== 1'b0) begin bad++; $display("FAIL basic_pulse got %0b want 0", b0.note_done); end
    total++; if (b0.last_dur !== 16'd14) begin bad++; $display("FAIL basic_keep got %0d want 14", b0.last_dur); end
  endtask

  task automatic test_legato();
    key_code = 8'd98;
    tick();
    repeat (5) tick();
    key_code = 8'd100;
    tick();
    total++; if (b0.note !== 4'd4) begin bad++; $display("FAIL leg_note got %0d want 4", b0.note); end
    total++; if (b0.note_done !== 1'b1) begin bad++; $display("FAIL leg_done got %0b want 1", b0.note_done); end
    total++; if (b0.last_dur !== 16'd6) begin bad++; $display("FAIL leg_last got %0d want 6", b0.last_dur); end
    total++; if (b0.playing !== 1'b1) begin bad++; $display("FAIL leg_play got %0b want 1", b0.playing); end
    total++; if (b1.last_dur !== 4'd6) begin bad++; $display("FAIL leg_last1 got %0d want 6", b1.last_dur); end
    key_code = 8'd0;
    repeat (6) tick();
  endtask

  task automatic test_retrigger();
    key_code = 8'd97;
    repeat (3) tick();
    key_code = 8'd0;
    repeat (2) tick();
    key_code = 8'd97;
    tick();
    total++; if (b0.note !== 4'd1) begin bad++; $display("FAIL retrig_note got %0d want 1", b0.note); end
    total++; if (b0.note_done !== 1'b0) begin bad++; $display("FAIL retrig_done got %0b want 0", b0.note_done); end
    repeat (2) tick();
    key_code = 8'd0;
    repeat (4) tick();
    tick();
    total++; if (b0.note_done !== 1'b1) begin bad++; $display("FAIL retrig_end got %0b want 1", b0.note_done); end
    total++; if (b0.last_dur !== 16'd12) begin bad++; $display("FAIL retrig_last got %0d want 12", b0.last_dur); end
  endtask

  task automatic test_range();
    key_code = 8'd105;
    tick();
    total++; if ({b0.playing, b0.note} !== 5'b0) begin bad++; $display("FAIL range_i got play=%0b note=%0d want 0", b0.playing, b0.note); end
    key_code = 8'd104;
    tick();
    total++; if (b0.note !== 4'd8) begin bad++; $display("FAIL range_h got %0d want 8", b0.note); end
    key_code = 8'd96;
    tick();
    total++; if ({b0.playing, b0.note} !== 5'b1_1000) begin bad++; $display("FAIL range_low got play=%0b note=%0d want tail of 8", b0.playing, b0.note); end
    key_code = 8'd0;
    repeat (5) tick();
    key_code = 8'd65;
    tick();
`ifdef FREE_PLAY_OCTAVE_EN
    total++; if ({b0.octave, b0.note} !== 5'b1_0001) begin bad++; $display("FAIL upper got oct=%0b note=%0d want oct=1 note=1", b0.octave, b0.note); end
`else
    total++; if ({b0.octave, b0.note} !== 5'b0) begin bad++; $display("FAIL upper got oct=%0b note=%0d want 0", b0.octave, b0.note); end
`endif
    key_code = 8'd97;
    tick();
    total++; if ({b0.octave, b0.note} !== 5'b0_0001) begin bad++; $display("FAIL lower got oct=%0b note=%0d want oct=0 note=1", b0.octave, b0.note); end
    key_code = 8'd0;
    repeat (6) tick();
  endtask

  task automatic test_stop();
    key_code = 8'd99;
    repeat (3) tick();
    stop = 1'b1;
    tick();
    total++; if (b0.active !== 1'b0) begin bad++; $display("FAIL stop_active got %0b want 0", b0.active); end
    total++; if (b0.note_done !== 1'b1) begin bad++; $display("FAIL stop_done got %0b want 1", b0.note_done); end
    total++; if (b0.last_dur !== 16'd3) begin bad++; $display("FAIL stop_last got %0d want 3", b0.last_dur); end
    total++; if ({b0.playing, b0.note} !== 5'b0) begin bad++; $display("FAIL stop_note got play=%0b note=%0d want 0", b0.playing, b0.note); end
    key_code = 8'd0;
    tick();
    total++; if (b0.note_done !== 1'b0) begin bad++; $display("FAIL stop_pulse got %0b want 0", b0.note_done); end
    start = 1'b1;
    tick();
    total++; if (b0.active !== 1'b0) begin bad++; $display("FAIL startstop got %0b want 0", b0.active); end
    stop = 1'b0;
    tick();
    start = 1'b0;
    total++; if (b0.active !== 1'b1) begin bad++; $display("FAIL rearm got %0b want 1", b0.active); end
    key_code = 8'd97;
    repeat (2) tick();
    #2;
    reset = 1'b1;
    #1;
    mreset();
    total++; if ({b0.note, b0.playing, b0.active} !== 6'b0) begin bad++; $display("FAIL midrst got note=%0d play=%0b act=%0b want 0", b0.note, b0.playing, b0.active); end
    total++; if ({b0.note_done, b0.last_dur} !== 17'b0) begin bad++; $display("FAIL midrst_done got done=%0b last=%0d want 0", b0.note_done, b0.last_dur); end
    tick();
    total++; if (b0.note_done !== 1'b0) begin bad++; $display("FAIL midrst_pulse got %0b want 0", b0.note_done); end
    reset = 1'b0;
    key_code = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_saturation();
    key_code = 8'd101;
    repeat (20) tick();
    key_code = 8'd0;
    tick();
    total++; if (b1.note_done !== 1'b1) begin bad++; $display("FAIL sat_done1 got %0b want 1", b1.note_done); end
    total++; if (b1.last_dur !== 4'd15) begin bad++; $display("FAIL sat_last1 got %0d want 15", b1.last_dur); end
    repeat (4) tick();
    tick();
    total++; if (b0.last_dur !== 16'd24) begin bad++; $display("FAIL sat_last0 got %0d want 24", b0.last_dur); end
  endtask

  task automatic test_random();
    int left;
    int r;
    left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (left == 0) begin
        r = int'($urandom_range(0, 9));
        if (r <= 5) key_code = 8'(KB + int'($urandom_range(0, NK - 1)));
        else if (r == 6) key_code = 8'd0;
        else if (r == 7) key_code = 8'(KB - 32 + int'($urandom_range(0, NK - 1)));
        else if (r == 8) key_code = ($urandom_range(0, 1) == 0) ? 8'(KB - 1) : 8'(KB + NK);
        else key_code = 8'($urandom_range(0, 255));
        left = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 25)) : int'($urandom_range(1, 6));
      end
      left--;
      stop = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 3) == 0);
      tick();
      total++; if (int'(b0.note) !== m0.snd) begin bad++; $display("FAIL rnd_note0 t=%0t got %0d want %0d", $time, b0.note, m0.snd); end
      total++; if (b0.octave !== m0.soct) begin bad++; $display("FAIL rnd_oct0 t=%0t got %0b want %0b", $time, b0.octave, m0.soct); end
      total++; if (b0.playing !== (m0.snd != 0)) begin bad++; $display("FAIL rnd_play0 t=%0t got %0b", $time, b0.playing); end
      total++; if (b0.active !== m0.mode) begin bad++; $display("FAIL rnd_act0 t=%0t got %0b want %0b", $time, b0.active, m0.mode); end
      total++; if (b0.note_done !== m0.done) begin bad++; $display("FAIL rnd_done0 t=%0t got %0b want %0b", $time, b0.note_done, m0.done); end
      total++; if (int'(b0.last_dur) !== m0.last) begin bad++; $display("FAIL rnd_last0 t=%0t got %0d want %0d", $time, b0.last_dur, m0.last); end
      total++; if (int'(b1.note) !== m1.snd) begin bad++; $display("FAIL rnd_note1 t=%0t got %0d want %0d", $time, b1.note, m1.snd); end
      total++; if (b1.octave !== m1.soct) begin bad++; $display("FAIL rnd_oct1 t=%0t got %0b want %0b", $time, b1.octave, m1.soct); end
      total++; if (b1.playing !== (m1.snd != 0)) begin bad++; $display("FAIL rnd_play1 t=%0t got %0b", $time, b1.playing); end
      total++; if (b1.active !== m1.mode) begin bad++; $display("FAIL rnd_act1 t=%0t got %0b want %0b", $time, b1.active, m1.mode); end
      total++; if (b1.note_done !== m1.done) begin bad++; $display("FAIL rnd_done1 t=%0t got %0b want %0b", $time, b1.note_done, m1.done); end
      total++; if (int'(b1.last_dur) !== m1.last) begin bad++; $display("FAIL rnd_last1 t=%0t got %0d want %0d", $time, b1.last_dur, m1.last); end
    end
    stop = 1'b0;
    start = 1'b0;
    key_code = 8'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_legato();
    test_retrigger();
    test_range();
    test_stop();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
